// File: rtl/pipeline_run_control_if.sv
// Debug/host command port of the pipeline run-control sequencer.
interface pipeline_run_control_if #(
    parameter int unsigned NB_CMD = 2
);
    logic              i_cmd_valid;
    logic [NB_CMD-1:0] i_cmd;
    logic              o_cmd_ready;

    modport master (output i_cmd_valid, output i_cmd, input  o_cmd_ready);
    modport slave  (input  i_cmd_valid, input  i_cmd, output o_cmd_ready);
endinterface

// File: rtl/pipeline_run_control.sv
// Run/step/halt sequencer gating PC and pipeline-register enables of the 5-stage MIPS core.
// Optional watchdog enabled by defining PIPE_RC_TIMEOUT_EN.
module pipeline_run_control #(
    parameter int unsigned               NB_INSTRUCCION = 6,
    parameter int unsigned               NB_CMD         = 2,
    parameter int unsigned               NB_CYCLE_CNT   = 32,
    parameter int unsigned               N_DRAIN        = 4,
    parameter logic [NB_INSTRUCCION-1:0] HALT_OPCODE    = 6'b111111,
    parameter logic [31:0]               MAX_CYCLES     = 32'd100000
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    pipeline_run_control_if.slave     cmd_bus,
    input  logic [NB_INSTRUCCION-1:0] i_opcode,
    output logic                      o_pc_enable,
    output logic                      o_pipe_enable,
    output logic                      o_flush_if,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_cmd_err,
    output logic                      o_timeout,
    output logic [NB_CYCLE_CNT-1:0]   o_cycle_count
);
    localparam int unsigned NB_DRAIN = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;

    localparam logic [NB_CMD-1:0] CMD_CLEAR = NB_CMD'(0);
    localparam logic [NB_CMD-1:0] CMD_RUN   = NB_CMD'(1);
    localparam logic [NB_CMD-1:0] CMD_STEP  = NB_CMD'(2);
    localparam logic [NB_CMD-1:0] CMD_HALT  = NB_CMD'(3);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t              state;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic                in_exec;
    logic                halt_seen;
    logic                cmd_ready;
    logic                cmd_accept;
    logic                timeout_hit;

    // Enables are decoded from the current state; the halt opcode in ID cuts fetch in the same cycle.
    assign in_exec       = (state == ST_RUN) || (state == ST_STEP);
    assign halt_seen     = in_exec && (i_opcode == HALT_OPCODE);
    assign cmd_ready     = (state == ST_IDLE) || (state == ST_RUN) || (state == ST_HALTED);
    assign cmd_accept    = cmd_bus.i_cmd_valid && cmd_ready;

    assign o_pc_enable   = in_exec && !halt_seen;
    assign o_pipe_enable = in_exec || (state == ST_DRAIN);
    assign o_flush_if    = halt_seen || (state == ST_DRAIN);
    assign o_busy        = in_exec || (state == ST_DRAIN);
    assign cmd_bus.o_cmd_ready = cmd_ready;

`ifdef PIPE_RC_TIMEOUT_EN
    assign timeout_hit = (state == ST_RUN) && !halt_seen &&
                         (o_cycle_count >= NB_CYCLE_CNT'(MAX_CYCLES - 32'd1));
`else
    logic unused_max_cycles;
    assign unused_max_cycles = ^MAX_CYCLES;
    assign timeout_hit       = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= ST_IDLE;
            drain_cnt     <= '0;
            o_done        <= 1'b0;
            o_cmd_err     <= 1'b0;
            o_timeout     <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            o_done    <= 1'b0;
            o_cmd_err <= 1'b0;

            // Saturating count of cycles in which the pipeline registers advance.
            if (o_pipe_enable && (o_cycle_count != '1)) begin
                o_cycle_count <= o_cycle_count + NB_CYCLE_CNT'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        case (cmd_bus.i_cmd)
                            CMD_CLEAR: begin
                                o_cycle_count <= '0;
                                o_timeout     <= 1'b0;
                            end
                            CMD_RUN:  state <= ST_RUN;
                            CMD_STEP: state <= ST_STEP;
                            CMD_HALT: begin
                                state     <= ST_DRAIN;
                                drain_cnt <= NB_DRAIN'(N_DRAIN - 1);
                            end
                            default: state <= ST_IDLE;
                        endcase
                    end
                end

                ST_RUN: begin
                    // Halt opcode, HALT command and watchdog all merge into one drain entry.
                    if (halt_seen || timeout_hit ||
                        (cmd_accept && (cmd_bus.i_cmd == CMD_HALT))) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= NB_DRAIN'(N_DRAIN - 1);
                    end
                    if (timeout_hit) begin
                        o_timeout <= 1'b1;
                    end
                    if (cmd_accept && (cmd_bus.i_cmd != CMD_HALT)) begin
                        o_cmd_err <= 1'b1;
                    end
                end

                ST_STEP: begin
                    drain_cnt <= NB_DRAIN'(N_DRAIN - 1);
                    state     <= halt_seen ? ST_DRAIN : ST_IDLE;
                end

                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state  <= ST_HALTED;
                        o_done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - NB_DRAIN'(1);
                    end
                end

                ST_HALTED: begin
                    if (cmd_accept) begin
                        if (cmd_bus.i_cmd == CMD_CLEAR) begin
                            state         <= ST_IDLE;
                            o_cycle_count <= '0;
                            o_timeout     <= 1'b0;
                        end else begin
                            o_cmd_err <= 1'b1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pipeline_run_control.sv
// Randomized self-checking bench for pipeline_run_control; expectations derived per cycle from run length.
module tb_pipeline_run_control;
    localparam int unsigned NB_INSTRUCCION = 6;
    localparam int unsigned NB_CMD         = 2;
    localparam int unsigned NB_CYCLE_CNT   = 32;
    localparam int unsigned N_DRAIN        = 4;
    localparam logic [5:0]  HALT_OP        = 6'b111111;
`ifdef PIPE_RC_TIMEOUT_EN
    localparam logic [31:0] MAX_CYC        = 32'd20;
`else
    localparam logic [31:0] MAX_CYC        = 32'd100000;
`endif
    localparam logic [1:0] C_CLEAR = 2'd0;
    localparam logic [1:0] C_RUN   = 2'd1;
    localparam logic [1:0] C_STEP  = 2'd2;
    localparam logic [1:0] C_HALT  = 2'd3;
    // Observation vector order: pc, pipe, flush, busy, ready, done, err
    localparam logic [6:0] OBS_IDLE  = 7'b0000100;
    localparam logic [6:0] OBS_STEP  = 7'b1101000;
    localparam logic [6:0] OBS_DRAIN = 7'b0111000;
    localparam logic [6:0] OBS_DONE  = 7'b0000110;
    localparam logic [6:0] OBS_ERR   = 7'b0000101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode;
    logic        pc_enable, pipe_enable, flush_if, busy, done, cmd_err, timeout;
    logic [31:0] cycle_count;
    int          n_tests = 0;
    int          n_fail = 0;

    pipeline_run_control_if #(.NB_CMD(NB_CMD)) cmd_bus();

    pipeline_run_control #(
        .NB_INSTRUCCION(NB_INSTRUCCION), .NB_CMD(NB_CMD), .NB_CYCLE_CNT(NB_CYCLE_CNT),
        .N_DRAIN(N_DRAIN), .HALT_OPCODE(HALT_OP), .MAX_CYCLES(MAX_CYC)
    ) dut (
        .i_clock(clk), .i_reset(rst_n), .cmd_bus(cmd_bus.slave), .i_opcode(opcode),
        .o_pc_enable(pc_enable), .o_pipe_enable(pipe_enable), .o_flush_if(flush_if),
        .o_busy(busy), .o_done(done), .o_cmd_err(cmd_err), .o_timeout(timeout),
        .o_cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {pc_enable, pipe_enable, flush_if, busy, cmd_bus.o_cmd_ready, done, cmd_err};
    endfunction

    function automatic logic [5:0] rand_op();
        return 6'($urandom_range(0, 62));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        cmd_bus.i_cmd_valid = 1'b1;
        cmd_bus.i_cmd       = C_RUN;
        opcode              = rand_op();
        tick();
        cmd_bus.i_cmd_valid = 1'b0;
        cmd_bus.i_cmd       = 2'($urandom_range(0, 3));
    endtask

    task automatic do_clear();
        cmd_bus.i_cmd_valid = 1'b1;
        cmd_bus.i_cmd       = C_CLEAR;
        tick();
        cmd_bus.i_cmd_valid = 1'b0;
        #1;
        n_tests++;
        if (obs() !== OBS_IDLE || cycle_count !== 32'd0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL clear obs=%b cnt=%0d to=%b expected obs=%b cnt=0 to=0",
                     obs(), cycle_count, timeout, OBS_IDLE);
        end
    endtask

    task automatic test_reset();
        cmd_bus.i_cmd_valid = 1'b0;
        cmd_bus.i_cmd       = C_RUN;
        opcode              = HALT_OP;
        rst_n               = 1'b0;
        #12;
        n_tests++;
        if (obs() !== OBS_IDLE || timeout !== 1'b0 || cycle_count !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state obs=%b to=%b cnt=%0d expected obs=%b to=0 cnt=0",
                     obs(), timeout, cycle_count, OBS_IDLE);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        // Reset in the middle of a run: everything returns immediately, no drain.
        start_run();
        for (int k = 1; k <= 7; k++) begin
            opcode = rand_op();
            tick();
        end
        n_tests++;
        if (cycle_count !== 32'd7 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_run_count cnt=%0d busy=%b expected cnt=7 busy=1", cycle_count, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (obs() !== OBS_IDLE || cycle_count !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset obs=%b cnt=%0d expected obs=%b cnt=0",
                     obs(), cycle_count, OBS_IDLE);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_run_halt(input int len);
        logic [6:0]  exp_obs;
        logic [31:0] exp_cnt;
        start_run();
        for (int k = 1; k <= len + 6; k++) begin
            opcode = (k == len) ? HALT_OP : rand_op();
            #1;
            exp_obs = {k < len, k <= len + 4, k >= len && k <= len + 4, k <= len + 4,
                       !(k > len && k <= len + 4), k == len + 5, 1'b0};
            exp_cnt = 32'((k - 1 < len + 4) ? k - 1 : len + 4);
            n_tests++;
            if (obs() !== exp_obs || cycle_count !== exp_cnt) begin
                n_fail++;
                $display("FAIL run_halt len=%0d cyc=%0d obs=%b cnt=%0d expected obs=%b cnt=%0d",
                         len, k, obs(), cycle_count, exp_obs, exp_cnt);
            end
            tick();
        end
        do_clear();
    endtask

    task automatic test_step();
        for (int s = 0; s < 3; s++) begin
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
            cmd_bus.i_cmd_valid = 1'b1;
            cmd_bus.i_cmd       = C_STEP;
            opcode              = rand_op();
            #1;
            n_tests++;
            if (obs() !== OBS_IDLE) begin
                n_fail++;
                $display("FAIL step_idle s=%0d obs=%b expected %b", s, obs(), OBS_IDLE);
            end
            tick();
            // A command offered during STEP must be ignored (ready low).
            cmd_bus.i_cmd = C_RUN;
            #1;
            n_tests++;
            if (obs() !== OBS_STEP) begin
                n_fail++;
                $display("FAIL step_pulse s=%0d obs=%b expected %b", s, obs(), OBS_STEP);
            end
            tick();
            cmd_bus.i_cmd_valid = 1'b0;
        end
        #1;
        n_tests++;
        if (obs() !== OBS_IDLE || cycle_count !== 32'd3) begin
            n_fail++;
            $display("FAIL step_total obs=%b cnt=%0d expected obs=%b cnt=3", obs(), cycle_count, OBS_IDLE);
        end
        do_clear();
    endtask

    task automatic test_halt_same_cycle(input int len);
        int   pipe_cycles = 0;
        int   done_cnt = 0;
        logic err_seen = 1'b0;
        start_run();
        for (int k = 1; k <= len + 6; k++) begin
            opcode              = (k == len) ? HALT_OP : rand_op();
            cmd_bus.i_cmd_valid = (k == len);
            cmd_bus.i_cmd       = C_HALT;
            #1;
            pipe_cycles += int'(pipe_enable);
            done_cnt    += int'(done);
            err_seen    |= cmd_err;
            tick();
        end
        cmd_bus.i_cmd_valid = 1'b0;
        n_tests++;
        if (pipe_cycles != len + 4 || done_cnt != 1 || err_seen !== 1'b0 ||
            cycle_count !== 32'(len + 4) || obs() !== OBS_IDLE) begin
            n_fail++;
            $display("FAIL halt_same_cycle len=%0d pipe=%0d done=%0d err=%b cnt=%0d obs=%b expected pipe=%0d done=1 err=0 obs=%b",
                     len, pipe_cycles, done_cnt, err_seen, cycle_count, obs(), len + 4, OBS_IDLE);
        end
    endtask

    // Entered in HALTED; exercises dropped commands in HALTED and RUN, and HALT from IDLE.
    task automatic test_cmd_errors();
        logic [31:0] held = cycle_count;
        for (int i = 0; i < 3; i++) begin
            cmd_bus.i_cmd_valid = 1'b1;
            cmd_bus.i_cmd       = 2'($urandom_range(1, 3));
            tick();
            cmd_bus.i_cmd_valid = 1'b0;
            #1;
            n_tests++;
            if (obs() !== OBS_ERR || cycle_count !== held) begin
                n_fail++;
                $display("FAIL halted_err i=%0d obs=%b cnt=%0d expected obs=%b cnt=%0d",
                         i, obs(), cycle_count, OBS_ERR, held);
            end
        end
        tick();
        n_tests++;
        if (obs() !== OBS_IDLE) begin
            n_fail++;
            $display("FAIL err_one_shot obs=%b expected %b", obs(), OBS_IDLE);
        end
        do_clear();
        start_run();
        opcode = rand_op();
        tick();
        cmd_bus.i_cmd_valid = 1'b1;
        cmd_bus.i_cmd       = 2'($urandom_range(0, 2));
        opcode              = rand_op();
        tick();
        cmd_bus.i_cmd = C_HALT;
        opcode        = rand_op();
        #1;
        n_tests++;
        if (obs() !== 7'b1101101) begin
            n_fail++;
            $display("FAIL run_err obs=%b expected %b", obs(), 7'b1101101);
        end
        tick();
        cmd_bus.i_cmd_valid = 1'b0;
        n_tests++;
        if (obs() !== OBS_DRAIN) begin
            n_fail++;
            $display("FAIL run_halt_cmd obs=%b expected %b", obs(), OBS_DRAIN);
        end
        for (int d = 0; d < 4; d++) tick();
        n_tests++;
        if (obs() !== OBS_DONE || cycle_count !== 32'd7) begin
            n_fail++;
            $display("FAIL run_halt_done obs=%b cnt=%0d expected obs=%b cnt=7", obs(), cycle_count, OBS_DONE);
        end
        do_clear();
        cmd_bus.i_cmd_valid = 1'b1;
        cmd_bus.i_cmd       = C_HALT;
        tick();
        cmd_bus.i_cmd_valid = 1'b0;
        n_tests++;
        if (obs() !== OBS_DRAIN) begin
            n_fail++;
            $display("FAIL idle_halt obs=%b expected %b", obs(), OBS_DRAIN);
        end
        for (int d = 0; d < 4; d++) tick();
        n_tests++;
        if (obs() !== OBS_DONE || cycle_count !== 32'd4) begin
            n_fail++;
            $display("FAIL idle_halt_done obs=%b cnt=%0d expected obs=%b cnt=4", obs(), cycle_count, OBS_DONE);
        end
        do_clear();
    endtask

`ifdef PIPE_RC_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] exp_obs;
        start_run();
        for (int k = 1; k <= 27; k++) begin
            opcode = rand_op();
            #1;
            exp_obs = {k <= 20, k <= 24, k > 20 && k <= 24, k <= 24,
                       !(k > 20 && k <= 24), k == 25, 1'b0, k > 20};
            n_tests++;
            if ({obs(), timeout} !== exp_obs) begin
                n_fail++;
                $display("FAIL timeout cyc=%0d obs=%b expected %b", k, {obs(), timeout}, exp_obs);
            end
            tick();
        end
        do_clear();
    endtask
`endif

    initial begin
        test_reset();
        test_run_halt(10);
        for (int r = 0; r < 3; r++) test_run_halt($urandom_range(1, 20));
        test_step();
        test_halt_same_cycle(5);
        test_cmd_errors();
        test_halt_same_cycle($urandom_range(1, 15));
        do_clear();
`ifdef PIPE_RC_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
